// File: rtl/beta_alu_issue_if.sv
// beta_alu_issue_if
//   Instruction handshake channel between an instruction source (UART loader
//   or fetch stage) and the beta_alu_issue front end.
//   instr       : Beta instruction word (opcode, rc, ra, rb / literal)
//   instr_valid : source presents a valid instruction
//   instr_ready : front end can accept an instruction this cycle
//   master = instruction source, slave = beta_alu_issue
interface beta_alu_issue_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output instr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/beta_alu_issue.sv
// beta_alu_issue
//   Instruction-side front end for the 32-bit Beta ALU. Accepts OP/OPC-format
//   instructions, reads operands from a 32-entry register file (R31 reads as
//   zero), drives the ALU's registered inputs and writes the result and flags
//   back two cycles after the handshake.
//   clk, rst      : clock and synchronous active-high reset
//   instr_if      : instruction handshake channel (slave side)
//   o_alu_a/b/fn  : registered ALU operands and 6-bit function code
//   i_alu_out     : combinational ALU result
//   i_alu_z/v/n   : combinational ALU flags
//   o_wb_*        : one-cycle write-back report (valid, index, data)
//   o_flags       : {z,v,n} captured at the last write-back
//   o_illegal     : one-cycle pulse for an undecodable opcode
//   i_dbg_addr    : debug read index
//   o_dbg_data    : registered debug read of the register file
module beta_alu_issue #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  beta_alu_issue_if.slave  instr_if,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [5:0]       o_alu_fn,
  input  logic [WIDTH-1:0] i_alu_out,
  input  logic             i_alu_z,
  input  logic             i_alu_v,
  input  logic             i_alu_n,
  output logic             o_wb_valid,
  output logic [4:0]       o_wb_addr,
  output logic [WIDTH-1:0] o_wb_data,
  output logic [2:0]       o_flags,
  output logic             o_illegal,
  input  logic [4:0]       i_dbg_addr,
  output logic [WIDTH-1:0] o_dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC} state_t;

  state_t           r_state;
  logic             r_ready;
  logic [31:0]      r_instr;
  logic [WIDTH-1:0] r_regs [0:30];
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [5:0]       r_alu_fn;
  logic             r_wb_valid;
  logic [4:0]       r_wb_addr;
  logic [WIDTH-1:0] r_wb_data;
  logic [2:0]       r_flags;
  logic             r_illegal;
  logic [WIDTH-1:0] r_dbg_data;

  logic [5:0]       w_opcode;
  logic [4:0]       w_rc;
  logic [4:0]       w_ra;
  logic [4:0]       w_rb;
  logic [15:0]      w_lit;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic [5:0]       w_fn;
  logic             w_legal;

  assign w_opcode = r_instr[31:26];
  assign w_rc     = r_instr[25:21];
  assign w_ra     = r_instr[20:16];
  assign w_rb     = r_instr[15:11];
  assign w_lit    = r_instr[15:0];

  // R31 is not stored; any read of index 31 yields zero.
  assign w_opa = (w_ra == 5'd31) ? '0 : r_regs[w_ra];

  // OPC instructions (opcode[4]=1) take a sign-extended literal as operand b.
  assign w_opb = w_opcode[4] ? {{(WIDTH-16){w_lit[15]}}, w_lit}
                             : ((w_rb == 5'd31) ? '0 : r_regs[w_rb]);

  // Opcode decode: the low nibble picks the ALU function, opcode[5] must be
  // set for an ALU-class instruction, and nibbles 7 and F have no function.
  always_comb begin
    w_fn    = 6'h00;
    w_legal = 1'b1;
    case (w_opcode[3:0])
      4'h0:    w_fn = 6'h00;
      4'h1:    w_fn = 6'h01;
      4'h2:    w_fn = 6'h02;
      4'h3:    w_fn = 6'h03;
      4'h4:    w_fn = 6'h33;
      4'h5:    w_fn = 6'h35;
      4'h6:    w_fn = 6'h37;
      4'h8:    w_fn = 6'h18;
      4'h9:    w_fn = 6'h1E;
      4'hA:    w_fn = 6'h16;
      4'hB:    w_fn = 6'h1A;
      4'hC:    w_fn = 6'h20;
      4'hD:    w_fn = 6'h21;
      4'hE:    w_fn = 6'h23;
      default: w_legal = 1'b0;
    endcase
    if (!w_opcode[5]) begin
      w_legal = 1'b0;
    end
  end

  // Main sequencer: IDLE accepts, DECODE loads the ALU inputs (or flags an
  // illegal opcode), EXEC captures the settled ALU result. The ALU input
  // registers are only written in DECODE, so the ALU output stays stable while
  // idle. Pulse outputs default low every cycle. Reset wins over everything,
  // which also aborts an instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_instr    <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_fn   <= '0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_flags    <= '0;
      r_illegal  <= 1'b0;
      for (int i = 0; i < 31; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_if.instr_valid && r_ready) begin
            r_instr <= instr_if.instr;
            r_ready <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!w_legal) begin
            r_illegal <= 1'b1;
            r_ready   <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_alu_a  <= w_opa;
            r_alu_b  <= w_opb;
            r_alu_fn <= w_fn;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_rc != 5'd31) begin
            r_regs[w_rc] <= i_alu_out;
          end
          r_flags    <= {i_alu_z, i_alu_v, i_alu_n};
          r_wb_valid <= 1'b1;
          r_wb_addr  <= w_rc;
          r_wb_data  <= i_alu_out;
          r_ready    <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Debug port: one-cycle registered read, sees writes from earlier edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dbg_data <= '0;
    end else begin
      r_dbg_data <= (i_dbg_addr == 5'd31) ? '0 : r_regs[i_dbg_addr];
    end
  end

  assign instr_if.instr_ready = r_ready;
  assign o_alu_a              = r_alu_a;
  assign o_alu_b              = r_alu_b;
  assign o_alu_fn             = r_alu_fn;
  assign o_wb_valid           = r_wb_valid;
  assign o_wb_addr            = r_wb_addr;
  assign o_wb_data            = r_wb_data;
  assign o_flags              = r_flags;
  assign o_illegal            = r_illegal;
  assign o_dbg_data           = r_dbg_data;

endmodule
